// File: rtl/otg_hpi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : otg_hpi_sequencer
// Description : Avalon-MM slave that runs one timed HPI bus cycle per transfer
//               on the CY7C67200 OTG controller pins.
// Revision    : 1.0  initial release
// ============================================================================
module otg_hpi_sequencer #(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 2,
  parameter int RECOVERY_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  input  logic        otg_int,
  output logic        irq
);

  localparam int C_MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int C_MAX_B = (HOLD_CYC > RECOVERY_CYC) ? HOLD_CYC : RECOVERY_CYC;
  localparam int C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_CW    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

  localparam logic [C_CW-1:0] C_SETUP_LD  = C_CW'(SETUP_CYC - 1);
  localparam logic [C_CW-1:0] C_STROBE_LD = C_CW'(STROBE_CYC - 1);
  localparam logic [C_CW-1:0] C_HOLD_LD   = C_CW'(HOLD_CYC - 1);
  localparam logic [C_CW-1:0] C_REC_LD    = C_CW'(RECOVERY_CYC - 1);
  localparam logic [C_CW-1:0] C_ZERO      = '0;
  localparam logic [C_CW-1:0] C_ONE       = C_CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t          r_state;
  logic [C_CW-1:0] r_cnt;
  logic            r_is_write;
  logic            r_ack;
  logic            r_int_meta;
  logic            w_req;

  assign w_req           = avs_chipselect & (avs_read | avs_write);
  assign avs_waitrequest = w_req & ~r_ack;

  // Every pin output changes only on a phase transition, so pins never glitch
  // and address/data stay frozen for the whole cs_n-low window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= C_ZERO;
      r_is_write   <= 1'b0;
      r_ack        <= 1'b0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_data_oe  <= 1'b0;
      otg_addr     <= 2'd0;
      otg_data_out <= 16'd0;
      avs_readdata <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (w_req) begin
            r_state      <= ST_SETUP;
            r_cnt        <= C_SETUP_LD;
            r_is_write   <= avs_write;
            otg_addr     <= avs_address;
            otg_data_out <= avs_writedata;
            otg_data_oe  <= avs_write;
            otg_cs_n     <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (r_cnt == C_ZERO) begin
            r_state  <= ST_STROBE;
            r_cnt    <= C_STROBE_LD;
            otg_rd_n <= r_is_write;
            otg_wr_n <= ~r_is_write;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        ST_STROBE: begin
          if (r_cnt == C_ZERO) begin
            r_state  <= ST_HOLD;
            r_cnt    <= C_HOLD_LD;
            otg_rd_n <= 1'b1;
            otg_wr_n <= 1'b1;
            r_ack    <= (HOLD_CYC == 1);
            if (!r_is_write) avs_readdata <= otg_data_in;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        ST_HOLD: begin
          if (r_cnt == C_ZERO) begin
            r_state     <= ST_RECOVER;
            r_cnt       <= C_REC_LD;
            r_ack       <= 1'b0;
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_ONE;
            r_ack <= (r_cnt == C_ONE);
          end
        end
        ST_RECOVER: begin
          r_ack <= 1'b0;
          if (r_cnt == C_ZERO) r_state <= ST_IDLE;
          else                 r_cnt   <= r_cnt - C_ONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int_meta <= 1'b0;
      irq        <= 1'b0;
    end else begin
      r_int_meta <= otg_int;
      irq        <= r_int_meta;
    end
  end

endmodule
`default_nettype wire
